life_cell_renderer: RTL and testbench

- Pipelined, parametrised pixel renderer for the Game of Life board. Maps VGA scan coordinates to grid cells and produces a 12-bit colour per pixel.
- Sits between the VGA timing generator and the life engine. Buffers each new generation and commits it only at frame start, so the display never tears.
- Extends the earlier fixed 4x4 combinational renderer with:
  - arbitrary grid size and cell size
  - three colour modes, including per-cell age
  - gridlines
  - a blinking cursor
  - registered outputs

---
 rtl/life_cell_renderer.sv | 221 ++++++++++++++++++++++
 tb/tb_life_cell_renderer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_cell_renderer.sv
// life_cell_renderer: maps VGA scan coordinates onto a GRID_W x GRID_H Game of
// Life board. The renderer buffers each new generation and commits it only at
// frame start, so the display never tears. It draws mono, history or per-cell
// age colours, plus gridlines and a blinking cursor.
// The pipeline has two register stages: coordinates, then registered colour.
module life_cell_renderer #(
    parameter int GRID_W       = 8,
    parameter int GRID_H       = 8,
    parameter int CELL_LOG2    = 6,
    parameter int COORD_W      = 11,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COORD_W-1:0]        x,
    input  logic [COORD_W-1:0]        y,
    input  logic                      video_on,
    input  logic                      frame_start,
    input  logic                      gen_valid,
    input  logic [GRID_W*GRID_H-1:0]  alive,
    input  logic [1:0]                color_mode,
    input  logic                      grid_en,
    input  logic                      cursor_en,
    input  logic [5:0]                cursor_x,
    input  logic [5:0]                cursor_y,
    output logic [11:0]               rgb,
    output logic                      rgb_valid,
    output logic                      committed
);

    localparam int N  = GRID_W * GRID_H;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [COORD_W-1:0] GRID_W_C   = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0] GRID_H_C   = COORD_W'(GRID_H);

    typedef enum logic [1:0] {
        MODE_MONO = 2'd0,
        MODE_HIST = 2'd1,
        MODE_AGE  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // ---------------- generation buffering / commit ----------------
    logic [N-1:0] cur_q, prev_q, stage_buf_q;
    logic         pending_q;
    logic         committed_q;
    logic [1:0]   age_q [N];
    logic [1:0]   age_d [N];
    logic         commit;
    logic [N-1:0] new_gen;

    // A gen_valid coinciding with frame_start bypasses the buffer straight into the commit.
    assign commit  = frame_start & (pending_q | gen_valid);
    assign new_gen = gen_valid ? alive : stage_buf_q;

    // Saturating per-cell age of the generation being committed.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            // NOTE: every always_comb output gets a value on every path; a missing default infers a latch.
            age_d[i] = 2'd0;
            if (new_gen[i]) begin
                age_d[i] = (age_q[i] == 2'd3) ? 2'd3 : age_q[i] + 2'd1;
            end
        end
    end

    // Capture pending generations and commit them at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q       <= '0;
            prev_q      <= '0;
            stage_buf_q <= '0;
            pending_q   <= 1'b0;
            committed_q <= 1'b0;
            // NOTE: the age array is only N two-bit flops, so it resets like any other register.
            for (int i = 0; i < N; i++) age_q[i] <= 2'd0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            committed_q <= commit;
            if (gen_valid) stage_buf_q <= alive;
            if (commit) begin
                prev_q    <= cur_q;
                cur_q     <= new_gen;
                pending_q <= 1'b0;
                for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
            end else if (gen_valid) begin
                pending_q <= 1'b1;
            end
        end
    end

    // ---------------- cursor blink ----------------
    logic [BW-1:0] blink_cnt_q;
    logic          blink_on_q;

    // Count frames and toggle the cursor every BLINK_FRAMES frame starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_on_q  <= ~blink_on_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- stage 1: coordinates to cell ----------------
    logic [COORD_W-1:0]   cx_d, cy_d;
    logic                 vis_d;
    logic [COORD_W-1:0]   cx_q, cy_q;
    logic [CELL_LOG2-1:0] ox_q, oy_q;
    logic                 vis_q, von_q;
    logic [1:0]           mode_q;
    logic                 grid_en_q, cursor_en_q;
    logic [5:0]           cursor_x_q, cursor_y_q;

    assign cx_d  = x >> CELL_LOG2;
    assign cy_d  = y >> CELL_LOG2;
    assign vis_d = video_on & (cx_d < GRID_W_C) & (cy_d < GRID_H_C);

    // Register the cell coordinates and the per-pixel controls that travel with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q        <= '0;
            cy_q        <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            vis_q       <= 1'b0;
            von_q       <= 1'b0;
            mode_q      <= 2'd0;
            grid_en_q   <= 1'b0;
            cursor_en_q <= 1'b0;
            cursor_x_q  <= '0;
            cursor_y_q  <= '0;
        end else begin
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            ox_q        <= x[CELL_LOG2-1:0];
            oy_q        <= y[CELL_LOG2-1:0];
            vis_q       <= vis_d;
            von_q       <= video_on;
            mode_q      <= color_mode;
            grid_en_q   <= grid_en;
            cursor_en_q <= cursor_en;
            cursor_x_q  <= cursor_x;
            cursor_y_q  <= cursor_y;
        end
    end

    // ---------------- stage 2: colour ----------------
    logic [IW-1:0] idx;
    logic          cell_cur, cell_prev;
    logic [1:0]    cell_age;
    logic          on_border, cursor_hit, grid_hit;
    logic [11:0]   cell_rgb;
    logic [11:0]   rgb_d;
    logic [11:0]   rgb_q;
    logic          rgb_valid_q;

    // Pick the cell colour from the committed state and apply overlays by priority.
    always_comb begin
        idx        = IW'(cy_q) * IW'(GRID_W) + IW'(cx_q);
        cell_cur   = cur_q[idx];
        cell_prev  = prev_q[idx];
        cell_age   = age_q[idx];
        on_border  = (ox_q == '0) | (ox_q == '1) | (oy_q == '0) | (oy_q == '1);
        // A cursor outside the grid can never match a visible cell, so it is never drawn.
        cursor_hit = cursor_en_q & blink_on_q & on_border &
                     (cx_q == COORD_W'(cursor_x_q)) & (cy_q == COORD_W'(cursor_y_q));
        grid_hit   = grid_en_q & ((ox_q == '0) | (oy_q == '0));

        cell_rgb = 12'h000;
        case (mode_e'(mode_q))
            MODE_HIST: begin
                case ({cell_prev, cell_cur})
                    2'b10:   cell_rgb = 12'hF00;
                    2'b01:   cell_rgb = 12'hFF0;
                    2'b11:   cell_rgb = 12'h0F0;
                    default: cell_rgb = 12'h000;
                endcase
            end
            MODE_AGE: begin
                case (cell_age)
                    2'd1:    cell_rgb = 12'hFF0;
                    2'd2:    cell_rgb = 12'h0F0;
                    2'd3:    cell_rgb = 12'h00F;
                    default: cell_rgb = 12'h000;
                endcase
            end
            default: cell_rgb = cell_cur ? 12'hFFF : 12'h000;
        endcase

        if (!vis_q)          rgb_d = 12'h000;
        else if (cursor_hit) rgb_d = 12'hF0F;
        else if (grid_hit)   rgb_d = 12'h444;
        else                 rgb_d = cell_rgb;
    end

    // Register the final pixel colour and its valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q       <= 12'h000;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= von_q;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;
    assign committed = committed_q;

endmodule

// File: tb/tb_life_cell_renderer.sv
// Self-checking bench for life_cell_renderer: directed steps plus randomized
// pixel streams compared against a behavioural model of the board.
module tb_life_cell_renderer;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int CL = 6;
    localparam int CW = 11;
    localparam int BF = 4;
    localparam int CS = 1 << CL;

    logic              clk = 1'b0;
    logic              rst;
    logic [CW-1:0]     x, y;
    logic              video_on, frame_start, gen_valid;
    logic [GW*GH-1:0]  alive;
    logic [1:0]        color_mode;
    logic              grid_en, cursor_en;
    logic [5:0]        cursor_x, cursor_y;
    logic [11:0]       rgb;
    logic              rgb_valid, committed;

    int checks   = 0;
    int failures = 0;

    life_cell_renderer #(
        .GRID_W(GW), .GRID_H(GH), .CELL_LOG2(CL), .COORD_W(CW), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on),
        .frame_start(frame_start), .gen_valid(gen_valid), .alive(alive),
        .color_mode(color_mode), .grid_en(grid_en), .cursor_en(cursor_en),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .rgb(rgb), .rgb_valid(rgb_valid), .committed(committed)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [GW*GH-1:0] m_cur, m_prev, m_buf;
    int               m_age [GW*GH];
    bit               m_pending;
    int               m_blink_cnt;
    bit               m_blink_on;

    task automatic model_reset();
        m_cur = '0; m_prev = '0; m_buf = '0; m_pending = 0;
        for (int i = 0; i < GW*GH; i++) m_age[i] = 0;
        m_blink_cnt = 0; m_blink_on = 1;
    endtask

    // Expected colour of pixel (px,py) under the current tb-driven controls.
    function automatic logic [11:0] ref_pix(input int px, input int py, input bit von);
        int cx, cy, ox, oy, i;
        bit edge_px;
        cx = px / CS; cy = py / CS; ox = px % CS; oy = py % CS;
        if (!von || cx >= GW || cy >= GH) return 12'h000;
        edge_px = (ox == 0) || (oy == 0) || (ox == CS-1) || (oy == CS-1);
        if (cursor_en && m_blink_on && edge_px && cx == int'(cursor_x) && cy == int'(cursor_y))
            return 12'hF0F;
        if (grid_en && (ox == 0 || oy == 0)) return 12'h444;
        i = cy * GW + cx;
        if (color_mode == 2'd1) begin
            if (m_prev[i] && m_cur[i]) return 12'h0F0;
            if (m_prev[i])             return 12'hF00;
            if (m_cur[i])              return 12'hFF0;
            return 12'h000;
        end
        if (color_mode == 2'd2) begin
            if (m_age[i] == 1) return 12'hFF0;
            if (m_age[i] == 2) return 12'h0F0;
            if (m_age[i] == 3) return 12'h00F;
            return 12'h000;
        end
        return m_cur[i] ? 12'hFFF : 12'h000;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of generation / frame events, then the model follows.
    task automatic frame_evt(input bit gv, input logic [GW*GH-1:0] data, input bit fs);
        bit exp_c;
        logic [GW*GH-1:0] nd;
        gen_valid = gv; alive = data; frame_start = fs;
        tick();
        gen_valid = 0; frame_start = 0;
        exp_c = fs && (m_pending || gv);
        if (exp_c) begin
            nd = gv ? data : m_buf;
            for (int i = 0; i < GW*GH; i++) m_age[i] = nd[i] ? ((m_age[i] + 1 > 3) ? 3 : m_age[i] + 1) : 0;
            m_prev = m_cur; m_cur = nd; m_pending = 0;
        end else if (gv) begin
            m_pending = 1;
        end
        if (gv) m_buf = data;
        if (fs) begin
            if (m_blink_cnt == BF-1) begin m_blink_cnt = 0; m_blink_on = !m_blink_on; end
            else m_blink_cnt++;
        end
        check("committed", {31'd0, committed}, {31'd0, exp_c});
    endtask

    // Hold one pixel for two cycles and compare against the model.
    task automatic pix(input string tag, input int px, input int py, input bit von);
        x = CW'(px); y = CW'(py); video_on = von;
        tick(); tick();
        check(tag, {20'd0, rgb}, {20'd0, ref_pix(px, py, von)});
        check({tag, "_valid"}, {31'd0, rgb_valid}, {31'd0, von});
    endtask

    // Random pixel stream, one pixel per cycle, each checked two cycles later.
    task automatic run_stream(input int n);
        logic [12:0] exp_q [$];
        logic [12:0] e;
        int px, py;
        bit von;
        for (int c = 0; c <= n; c++) begin
            if (c < n) begin
                if ($urandom_range(0, 1) == 0) begin
                    px = $urandom_range(0, 600);
                    py = $urandom_range(0, 600);
                end else begin
                    px = $urandom_range(0, 8) * CS + ($urandom_range(0, 1) ? 0 : CS - 1);
                    py = $urandom_range(0, 8) * CS + $urandom_range(0, CS - 1);
                end
                von        = ($urandom_range(0, 3) != 0);
                color_mode = 2'($urandom);
                grid_en    = 1'($urandom);
                cursor_en  = ($urandom_range(0, 3) != 0);
                cursor_x   = 6'($urandom_range(0, 9));
                cursor_y   = 6'($urandom_range(0, 9));
                x = CW'(px); y = CW'(py); video_on = von;
                exp_q.push_back({von, ref_pix(px, py, von)});
            end else begin
                video_on = 0;
            end
            tick();
            if (c >= 1) begin
                e = exp_q.pop_front();
                check("stream_rgb", {20'd0, rgb}, {20'd0, e[11:0]});
                check("stream_valid", {31'd0, rgb_valid}, {31'd0, e[12]});
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [GW*GH-1:0] r1, r2;
        rst = 1; x = '0; y = '0; video_on = 1; frame_start = 0; gen_valid = 0;
        alive = '0; color_mode = 0; grid_en = 0; cursor_en = 0; cursor_x = 0; cursor_y = 0;
        model_reset();

        // Reset holds outputs low even with video_on high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_rgb", {20'd0, rgb}, 32'h0);
            check("reset_valid", {31'd0, rgb_valid}, 32'h0);
            check("reset_committed", {31'd0, committed}, 32'h0);
        end
        rst = 0;
        tick();
        check("release_valid_1", {31'd0, rgb_valid}, 32'h0);
        tick();
        check("release_valid_2", {31'd0, rgb_valid}, 32'h1);
        check("release_rgb", {20'd0, rgb}, 32'h0);

        // Commit timing: buffered data shows only after frame_start.
        color_mode = 2'd0;
        frame_evt(1, 64'h200, 0);
        pix("pre_commit", 100, 100, 1);
        check("pre_commit_const", {20'd0, rgb}, 32'h000);
        frame_evt(0, '0, 1);
        tick();
        check("commit_once", {31'd0, committed}, 32'h0);
        pix("post_commit", 100, 100, 1);
        check("post_commit_const", {20'd0, rgb}, 32'hFFF);
        frame_evt(0, '0, 1);

        // History and age, with gen_valid and frame_start together.
        frame_evt(1, 64'h400, 1);
        color_mode = 2'd1;
        pix("hist_prev", 100, 100, 1);
        check("hist_prev_const", {20'd0, rgb}, 32'hF00);
        pix("hist_new", 160, 100, 1);
        check("hist_new_const", {20'd0, rgb}, 32'hFF0);
        frame_evt(1, 64'h400, 0);
        frame_evt(0, '0, 1);
        frame_evt(1, 64'h400, 1);
        color_mode = 2'd2;
        pix("age_sat", 160, 100, 1);
        check("age_sat_const", {20'd0, rgb}, 32'h00F);

        // Double gen_valid: latest wins, prev keeps the pre-commit board.
        r1 = {$urandom, $urandom};
        r2 = {$urandom, $urandom};
        frame_evt(1, r1, 0);
        frame_evt(1, r2, 0);
        frame_evt(0, '0, 1);
        run_stream(60);

        // Random generations interleaved with random pixel streams.
        for (int k = 0; k < 8; k++) begin
            frame_evt(1'($urandom), {$urandom, $urandom}, 1'($urandom));
            frame_evt(1'($urandom), {$urandom, $urandom}, 1'($urandom));
            run_stream(50);
        end

        // Overlays from a clean reset.
        rst = 1; tick(); rst = 0; model_reset();
        color_mode = 0; grid_en = 1; cursor_en = 0; cursor_x = 1; cursor_y = 1;
        pix("grid", 64, 70, 1);
        check("grid_const", {20'd0, rgb}, 32'h444);
        cursor_en = 1;
        pix("cursor_corner", 64, 64, 1);
        check("cursor_corner_const", {20'd0, rgb}, 32'hF0F);
        pix("cursor_far_edge", 127, 100, 1);
        check("cursor_far_edge_const", {20'd0, rgb}, 32'hF0F);
        pix("cursor_inside", 100, 100, 1);
        check("cursor_inside_const", {20'd0, rgb}, 32'h000);
        for (int i = 0; i < BF-1; i++) frame_evt(0, '0, 1);
        pix("blink_still_on", 64, 64, 1);
        check("blink_still_on_const", {20'd0, rgb}, 32'hF0F);
        frame_evt(0, '0, 1);
        pix("blink_off", 64, 64, 1);
        check("blink_off_const", {20'd0, rgb}, 32'h444);
        for (int i = 0; i < BF; i++) frame_evt(0, '0, 1);
        cursor_x = 6'd8;
        pix("cursor_oob", 511, 100, 1);
        check("cursor_oob_const", {20'd0, rgb}, 32'h000);

        // Bounds: pixels just past the board are black but still valid.
        grid_en = 0; cursor_en = 0;
        pix("bound_x", GW*CS, 100, 1);
        check("bound_x_const", {20'd0, rgb}, 32'h000);
        pix("bound_y", 100, GH*CS, 1);
        check("bound_y_const", {20'd0, rgb}, 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
